// File: rtl/fizzle_pkg.sv
// fizzle_pkg: shared types and constants for the fizzlefade sequencer.
// Holds the controller state encoding, the 15-bit maximal LFSR taps and
// seed, and a helper for the framebuffer pixel count.
package fizzle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_STEP,
      ST_WRITE,
      ST_GAP
   } fizzle_state_t;

   localparam int          LFSR_LEN  = 15;
   localparam logic [14:0] LFSR_TAPS = 15'h6000;
   localparam logic [14:0] LFSR_SEED = 15'd1;

   // Number of pixels the fade has to cover.
   function automatic int FB_PIXELS(input int width, input int height);
      return width * height;
   endfunction

endpackage

// File: rtl/fizzle_ctrl_lfsr.sv
// lfsr: Galois right-shift LFSR with a synchronous load and a step enable.
// state_next always shows the value the register takes on the next step,
// so the owner can test for wrap-around before committing the step.
module lfsr #(
   parameter int             LEN     = 15,
   parameter logic [LEN-1:0] TAPS    = LEN'(1) << (LEN - 1),
   parameter logic [LEN-1:0] RST_VAL = LEN'(1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [LEN-1:0] seed,
   output logic [LEN-1:0] state,
   output logic [LEN-1:0] state_next
);

   // Feedback: shift right and fold the taps in when the bit leaving is set.
   always_comb begin
      state_next = (state >> 1) ^ (state[0] ? TAPS : '0);
   end

   // Shift register: load takes priority over stepping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_VAL;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= state_next;
      end
   end

endmodule

// File: rtl/fizzle_ctrl.sv
// fizzle_ctrl: fizzlefade sequencer. Waits a number of frames, then walks
// a 15-bit maximal LFSR and writes every framebuffer pixel exactly once
// through a valid/ready write port, pacing accepted writes by a cycle gap.
// Optional feature: define FIZZLE_CTRL_PROGRESS_EN to build the progress
// counter; without it progress is tied to zero.
module fizzle_ctrl
   import fizzle_pkg::*;
#(
   parameter int FB_WIDTH  = 160,
   parameter int FB_HEIGHT = 120,
   parameter int ADDRW     = 15,
   parameter int DATAW     = 4,
   parameter int WAITW     = 8,
   parameter int RATEW     = 16
) (
   input  logic             clk_sys,
   input  logic             rst_sys_n,
   input  logic             start,
   input  logic             abort,
   input  logic             frame_sys,
   input  logic [WAITW-1:0] wait_frames,
   input  logic [RATEW-1:0] rate,
   input  logic [DATAW-1:0] colr,
   output logic             fb_we,
   output logic [ADDRW-1:0] fb_addr,
   output logic [DATAW-1:0] fb_colr,
   input  logic             fb_ready,
   output logic             busy,
   output logic             done,
   output logic [ADDRW-1:0] progress
);

   localparam int                PIXELS   = FB_PIXELS(FB_WIDTH, FB_HEIGHT);
   localparam logic [LFSR_LEN:0] PIXELS_L = (LFSR_LEN + 1)'(PIXELS);

   fizzle_state_t       state, state_nxt;
   logic [WAITW-1:0]    wait_lat, frame_cnt;
   logic [RATEW-1:0]    rate_lat, gap_cnt;
   logic [DATAW-1:0]    colr_lat;
   logic [LFSR_LEN-1:0] lfsr_s, lfsr_nxt, cand;
   logic                cand_ok, hs, wrap;
   logic                lfsr_load, lfsr_step, latch_cfg;
   logic                we_set, count_write, done_nxt;

   lfsr #(
      .LEN     (LFSR_LEN),
      .TAPS    (LFSR_TAPS),
      .RST_VAL (LFSR_SEED)
   ) u_lfsr (
      .clk        (clk_sys),
      .rst_n      (rst_sys_n),
      .load       (lfsr_load),
      .step       (lfsr_step),
      .seed       (LFSR_SEED),
      .state      (lfsr_s),
      .state_next (lfsr_nxt)
   );

   // Candidate address is the LFSR state minus one; states past the pixel
   // count are skipped. A wrap back to the seed means every state was seen.
   always_comb begin
      cand    = lfsr_s - 1'b1;
      cand_ok = ({1'b0, cand} < PIXELS_L);
      hs      = fb_we && fb_ready;
      wrap    = (lfsr_nxt == LFSR_SEED);
   end

   // Next-state and control strobes; abort beats everything outside IDLE.
   always_comb begin
      state_nxt   = state;
      lfsr_load   = 1'b0;
      lfsr_step   = 1'b0;
      latch_cfg   = 1'b0;
      we_set      = 1'b0;
      count_write = 1'b0;
      done_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               latch_cfg = 1'b1;
               lfsr_load = 1'b1;
               state_nxt = (wait_frames == '0) ? ST_STEP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (frame_sys && ((frame_cnt + 1'b1) == wait_lat)) begin
               state_nxt = ST_STEP;
            end
         end
         ST_STEP: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (cand_ok) begin
               we_set    = 1'b1;
               state_nxt = ST_WRITE;
            end else begin
               lfsr_step = 1'b1;
               if (wrap) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_WRITE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (hs) begin
               lfsr_step   = 1'b1;
               count_write = 1'b1;
               if (wrap) begin
                  done_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (rate_lat == '0) begin
                  state_nxt = ST_STEP;
               end else begin
                  state_nxt = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (gap_cnt <= RATEW'(1)) begin
               state_nxt = ST_STEP;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register plus registered busy and done status.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != ST_IDLE);
         done  <= done_nxt;
      end
   end

   // Configuration captured at start, frame counter and write-gap counter.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         wait_lat  <= '0;
         rate_lat  <= '0;
         colr_lat  <= '0;
         frame_cnt <= '0;
         gap_cnt   <= '0;
      end else begin
         if (latch_cfg) begin
            wait_lat  <= wait_frames;
            rate_lat  <= rate;
            colr_lat  <= colr;
            frame_cnt <= '0;
         end else if ((state == ST_WAIT) && frame_sys) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
         if (count_write) begin
            gap_cnt <= rate_lat;
         end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   // Write port: request is held stable until accepted or aborted.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         fb_we   <= 1'b0;
         fb_addr <= '0;
         fb_colr <= '0;
      end else if (we_set) begin
         fb_we   <= 1'b1;
         fb_addr <= ADDRW'(cand);
         fb_colr <= colr_lat;
      end else if ((state == ST_WRITE) && (hs || abort)) begin
         fb_we   <= 1'b0;
      end
   end

`ifdef FIZZLE_CTRL_PROGRESS_EN
   // Accepted-write counter; cleared on start, held across an abort.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         progress <= '0;
      end else if (latch_cfg) begin
         progress <= '0;
      end else if (count_write) begin
         progress <= progress + 1'b1;
      end
   end
`else
   assign progress = '0;
`endif

endmodule

// File: tb/tb_fizzle_ctrl.sv
// tb_fizzle_ctrl: scoreboard bench for fizzle_ctrl. Expected writes are
// queued before stimulus and a negedge monitor pops them on each handshake.
module tb_fizzle_ctrl;

   localparam int ADDRW  = 15;
   localparam int DATAW  = 4;
   localparam int PIXELS = 19200;

`ifdef FIZZLE_CTRL_PROGRESS_EN
   localparam int PROG_ON = 1;
`else
   localparam int PROG_ON = 0;
`endif

   typedef struct packed {
      logic [ADDRW-1:0] addr;
      logic [DATAW-1:0] colr;
   } wr_t;

   logic             clk_sys = 1'b0;
   logic             rst_sys_n;
   logic             start, abort, frame_sys, fb_ready;
   logic [7:0]       wait_frames;
   logic [15:0]      rate;
   logic [DATAW-1:0] colr;
   logic             fb_we, busy, done;
   logic [ADDRW-1:0] fb_addr, progress;
   logic [DATAW-1:0] fb_colr;

   int  checks = 0;
   int  errors = 0;
   int  edge_cnt = 0;
   int  hs_count = 0;
   int  done_count = 0;
   int  done_edge = 0;
   int  done_busy = 0;
   int  start_edge = 0;
   int  dup_err = 0;
   int  range_err = 0;
   bit  track = 1'b0;
   bit  seen [0:32767];
   int  hs_edges [$];
   wr_t exp_q [$];

   fizzle_ctrl #(
      .FB_WIDTH  (160),
      .FB_HEIGHT (120),
      .ADDRW     (ADDRW),
      .DATAW     (DATAW),
      .WAITW     (8),
      .RATEW     (16)
   ) dut (
      .clk_sys     (clk_sys),
      .rst_sys_n   (rst_sys_n),
      .start       (start),
      .abort       (abort),
      .frame_sys   (frame_sys),
      .wait_frames (wait_frames),
      .rate        (rate),
      .colr        (colr),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_colr     (fb_colr),
      .fb_ready    (fb_ready),
      .busy        (busy),
      .done        (done),
      .progress    (progress)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every handshake and tracks coverage.
   always @(negedge clk_sys) begin
      wr_t e;
      if (rst_sys_n) begin
         if (done) begin
            done_count++;
            done_edge = edge_cnt;
            done_busy = int'(busy);
         end
         if (fb_we && fb_ready) begin
            hs_count++;
            hs_edges.push_back(edge_cnt);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("wr_addr", 32'(fb_addr), 32'(e.addr));
               checkOutput("wr_colr", 32'(fb_colr), 32'(e.colr));
            end
            if (track) begin
               if (int'(fb_addr) >= PIXELS) range_err++;
               else if (seen[fb_addr]) dup_err++;
               else seen[fb_addr] = 1'b1;
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] w, input logic [15:0] r, input logic [DATAW-1:0] c);
      @(posedge clk_sys); #1;
      wait_frames = w;
      rate        = r;
      colr        = c;
      start       = 1'b1;
      @(posedge clk_sys); #1;
      start      = 1'b0;
      start_edge = edge_cnt;
   endtask

   task automatic pulseAbort();
      @(posedge clk_sys); #1;
      abort = 1'b1;
      @(posedge clk_sys); #1;
      abort = 1'b0;
   endtask

   task automatic pulseFrame();
      @(posedge clk_sys); #1;
      frame_sys = 1'b1;
      @(posedge clk_sys); #1;
      frame_sys = 1'b0;
   endtask

   task automatic waitHs(input int target, input int budget, input string name);
      int n = 0;
      while (hs_count < target && n < budget) begin
         @(negedge clk_sys); #1;
         n++;
      end
      checkOutput(name, 32'(hs_count >= target), 32'd1);
   endtask

   task automatic waitWe(input int budget, input string name);
      int n = 0;
      while (!fb_we && n < budget) begin
         @(negedge clk_sys); #1;
         n++;
      end
      checkOutput(name, 32'(fb_we), 32'd1);
   endtask

   initial begin
      int base;
      rst_sys_n   = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      frame_sys   = 1'b0;
      fb_ready    = 1'b0;
      wait_frames = '0;
      rate        = '0;
      colr        = '0;

      // Reset state
      repeat (3) @(negedge clk_sys);
      checkOutput("rst_we", 32'(fb_we), 0);
      checkOutput("rst_addr", 32'(fb_addr), 0);
      checkOutput("rst_colr", 32'(fb_colr), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_progress", 32'(progress), 0);
      @(posedge clk_sys); #1;
      rst_sys_n = 1'b1;

      // First writes: address 0 at k+2, skip 24575, then 12287
      fb_ready = 1'b1;
      hs_edges.delete();
      exp_q.push_back('{addr: 15'd0, colr: 4'd5});
      exp_q.push_back('{addr: 15'd12287, colr: 4'd5});
      base = hs_count;
      applyStimulus(8'd0, 16'd0, 4'd5);
      @(negedge clk_sys);
      checkOutput("step_we_low", 32'(fb_we), 0);
      checkOutput("step_busy", 32'(busy), 1);
      @(negedge clk_sys);
      checkOutput("first_we", 32'(fb_we), 1);
      checkOutput("first_addr", 32'(fb_addr), 0);
      waitHs(base + 2, 20, "first_hs_timeout");
      if (hs_edges.size() >= 2)
         checkOutput("skip_spacing", 32'(hs_edges[1] - hs_edges[0]), 32'd3);
      @(posedge clk_sys); #1;
      fb_ready = 1'b0;

      // Handshake hold: third write 6143 stalls for five cycles
      waitWe(10, "hold_we_timeout");
      checkOutput("hold_addr0", 32'(fb_addr), 32'd6143);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_sys);
         checkOutput("hold_we", 32'(fb_we), 1);
         checkOutput("hold_addr", 32'(fb_addr), 32'd6143);
         checkOutput("hold_colr", 32'(fb_colr), 32'd5);
      end

      // Abort during WRITE
      pulseAbort();
      @(negedge clk_sys);
      checkOutput("abort_we", 32'(fb_we), 0);
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_no_done", 32'(done_count), 0);
      checkOutput("abort_progress", 32'(progress), 32'(2 * PROG_ON));

      // start and abort together in IDLE
      @(posedge clk_sys); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk_sys); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk_sys);
      checkOutput("start_abort_busy", 32'(busy), 0);
      checkOutput("start_abort_we", 32'(fb_we), 0);

      // Frame wait of 3, rate 4, start while busy ignored
      fb_ready = 1'b1;
      hs_edges.delete();
      exp_q.push_back('{addr: 15'd0, colr: 4'd9});
      exp_q.push_back('{addr: 15'd12287, colr: 4'd9});
      exp_q.push_back('{addr: 15'd6143, colr: 4'd9});
      base = hs_count;
      applyStimulus(8'd3, 16'd4, 4'd9);
      for (int f = 0; f < 3; f++) begin
         repeat (3) @(negedge clk_sys);
         checkOutput("wait_we_low", 32'(fb_we), 0);
         checkOutput("wait_busy", 32'(busy), 1);
         pulseFrame();
      end
      @(negedge clk_sys);
      checkOutput("wait_step_we", 32'(fb_we), 0);
      @(negedge clk_sys);
      checkOutput("wait_first_we", 32'(fb_we), 1);
      checkOutput("wait_first_addr", 32'(fb_addr), 0);
      waitHs(base + 1, 10, "wait_hs1_timeout");
      applyStimulus(8'd0, 16'd0, 4'd3);
      waitHs(base + 3, 40, "pace_hs_timeout");
      if (hs_edges.size() >= 3) begin
         checkOutput("pace_skip", 32'(hs_edges[1] - hs_edges[0]), 32'd7);
         checkOutput("pace_noskip", 32'(hs_edges[2] - hs_edges[1]), 32'd6);
      end
      pulseAbort();
      @(negedge clk_sys);
      checkOutput("pace_abort_busy", 32'(busy), 0);

      // Asynchronous reset mid-WRITE, then restart at address 0
      fb_ready = 1'b0;
      applyStimulus(8'd0, 16'd0, 4'd6);
      waitWe(10, "rstw_we_timeout");
      @(posedge clk_sys); #3;
      rst_sys_n = 1'b0;
      #1;
      checkOutput("arst_we", 32'(fb_we), 0);
      checkOutput("arst_addr", 32'(fb_addr), 0);
      checkOutput("arst_colr", 32'(fb_colr), 0);
      checkOutput("arst_busy", 32'(busy), 0);
      checkOutput("arst_progress", 32'(progress), 0);
      @(posedge clk_sys); #1;
      rst_sys_n = 1'b1;
      fb_ready  = 1'b1;
      exp_q.push_back('{addr: 15'd0, colr: 4'd7});
      base = hs_count;
      applyStimulus(8'd0, 16'd0, 4'd7);
      waitHs(base + 1, 10, "restart_hs_timeout");
      pulseAbort();

      // Full fade with fb_ready high
      for (int i = 0; i < 32768; i++) seen[i] = 1'b0;
      @(negedge clk_sys);
      hs_count   = 0;
      done_count = 0;
      track      = 1'b1;
      applyStimulus(8'd0, 16'd0, 4'd2);
      begin
         int n = 0;
         while (done_count == 0 && n < 60000) begin
            @(negedge clk_sys); #1;
            n++;
         end
      end
      checkOutput("fade_done_seen", 32'(done_count), 1);
      checkOutput("fade_cycles", 32'(done_edge - start_edge), 32'd51967);
      checkOutput("fade_busy_at_done", 32'(done_busy), 0);
      repeat (5) @(negedge clk_sys);
      track = 1'b0;
      checkOutput("fade_hs_count", 32'(hs_count), 32'(PIXELS));
      checkOutput("fade_dups", 32'(dup_err), 0);
      checkOutput("fade_range", 32'(range_err), 0);
      checkOutput("fade_done_once", 32'(done_count), 1);
      checkOutput("fade_progress", 32'(progress), 32'(PIXELS * PROG_ON));
      checkOutput("fade_idle_we", 32'(fb_we), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fizzle_ctrl.md
# fizzle_ctrl

Sequencer for the fizzlefade effect: waits a programmable number of frames, then walks a 15-bit maximal LFSR to write every framebuffer pixel exactly once in pseudo-random order. Writes are paced by a programmable cycle gap. It sits in the system clock domain between the frame flag, already synchronised to `clk_sys`, and the framebuffer write port. That write port is shared with other drawing engines, so every write uses a valid/ready handshake.

## Interface
- `FB_WIDTH`, 160: framebuffer width in pixels
- `FB_HEIGHT`, 120: framebuffer height in pixels
- `ADDRW`, 15: framebuffer address width; must satisfy `2**ADDRW-1 >= FB_WIDTH*FB_HEIGHT`
- `DATAW`, 4: colour index width
- `WAITW`, 8: width of the frame-wait count
- `RATEW`, 16: width of the write-gap count
- `clk_sys  input  1  system clock`
- `rst_sys_n  input  1  asynchronous, active-low reset`
- `start  input  1  one-cycle request to begin a fade; honoured only in IDLE`
- `abort  input  1  return to IDLE immediately; wins over start`
- `frame_sys  input  1  start-of-frame pulse in the clk_sys domain`
- `wait_frames  input  WAITW  frames to wait before the first write; sampled on start`
- `rate  input  RATEW  idle cycles after each accepted write; sampled on start`
- `colr  input  DATAW  fade colour index; sampled on start`
- `fb_we  output  1  write valid`
- `fb_addr  output  ADDRW  write address`
- `fb_colr  output  DATAW  write data`
- `fb_ready  input  1  write port grant; a transfer occurs on a clock edge where fb_we && fb_ready`
- `busy  output  1  high in any state other than IDLE`
- `done  output  1  one-cycle pulse after the final write`
- `progress  output  ADDRW  count of accepted writes in the current fade`

## Operation
- States: IDLE, WAIT, STEP, WRITE, GAP.
- **IDLE**
  - On `start && !abort`: latch `wait_frames`, `rate` and `colr`; load the LFSR with seed 1; clear `progress`.
  - Then go to WAIT, or directly to STEP if `wait_frames == 0`.
- **WAIT**
  - Each `frame_sys` pulse increments the frame counter.
  - When the count reaches the latched `wait_frames`, go to STEP.
- **LFSR**
  - Galois right-shift: next = `(s>>1) ^ (s[0] ? 15'h6000 : 0)`, i.e. x^15+x^14+1.
  - The LFSR never holds 0 and visits all 32767 non-zero states.
  - Candidate address = `s-1`, range 0..32766.
- **STEP**
  - If `s-1 < FB_WIDTH*FB_HEIGHT`: register `fb_we=1`, `fb_addr=s-1`, `fb_colr=latched colr`; go to WRITE.
  - Otherwise, skip: advance the LFSR; if the new state equals the seed, go to IDLE and pulse `done`; else stay in STEP.
  - A skip costs exactly one cycle and never consumes a gap.
- **WRITE**
  - Hold `fb_we`, `fb_addr` and `fb_colr` stable until the handshake completes.
  - On handshake: drop `fb_we`, increment `progress`, advance the LFSR.
  - If the new state equals the seed, go to IDLE and pulse `done`.
  - Else go to GAP with the counter loaded to the latched `rate`, or directly to STEP if `rate == 0`.
- **GAP**: count down to 1, then go to STEP.
- **Abort**: from any non-IDLE state go to IDLE next edge; `fb_we` drops, even mid-handshake; no `done` pulse. `progress` holds its value.
- `start` while `busy` is ignored.
- A `frame_sys` pulse outside WAIT is ignored.
- Exactly `FB_WIDTH*FB_HEIGHT` writes occur per completed fade; no address is written twice.

## Timing
- Reset values: state IDLE; `fb_we=0`, `fb_addr=0`, `fb_colr=0`, `busy=0`, `done=0`, `progress=0`; LFSR=1.
- All outputs are registered.
- With `start` sampled at edge k and `wait_frames=0`:
  - STEP during cycle k+1.
  - `fb_we` high from cycle k+2, with `fb_addr=0`.
- Minimum spacing between accepts (`fb_ready` high, no skips) is `rate+2` cycles.
- `done` is high in the cycle after the final handshake; `busy` is low in that same cycle.
- A full fade with `fb_ready` tied high and no aborts takes `32767 + 19200*(rate+1)` cycles from STEP entry, plus the wait.

## Configuration
- `FIZZLE_CTRL_PROGRESS_EN`
  - Defined: the `progress` counter is built as described in Operation.
  - Undefined: the counter is not synthesised and `progress` is tied to 0.

## Structure
- Package `fizzle_pkg` holds:
  - the state enum `fizzle_state_t`
  - `LFSR_TAPS=15'h6000` and `LFSR_SEED=15'd1`
  - `FB_PIXELS` as a function of width and height
- Sub-module: the existing `lfsr` (LEN=15, taps from the package), stepped by an enable from the FSM.
- The FSM, counters and output registers live in `fizzle_ctrl`.

## Test plan
- **Reset**: assert `rst_sys_n=0` mid-WRITE → all outputs return to their reset values asynchronously; the next `start` begins again at address 0.
- **First writes**: `start` with `wait_frames=0`, `rate=0`, `fb_ready=1` →
  - first write at address 0 in cycle k+2;
  - next candidate 24575 is skipped (1 cycle);
  - second write at address 12287.
- **Frame wait**: `wait_frames=3` → no `fb_we` until the third `frame_sys` pulse; STEP follows on the next edge.
- **Handshake and pacing**:
  - `fb_ready` low for 5 cycles → `fb_we`, `fb_addr` and `fb_colr` held stable throughout.
  - `rate=4` → accepts spaced by 6 cycles when no skips intervene.
- **Full fade**: `fb_ready` tied high → exactly 19200 handshakes, all addresses in 0..19199 unique; `done` pulses once; `progress=19200`.
- **Abort and start priority**:
  - `abort` during WRITE → `fb_we` low next cycle, no `done`.
  - `start` and `abort` together in IDLE → remains IDLE.
  - `start` while busy → ignored.
